aes_axil_regs: RTL and testbench
================================

// Module: aes_axil_regs
// PURPOSE
//   AXI-Lite slave register file for the AES-CTR core. It is the responder for the key/IV/start configuration master.
//   Holds KEY[127:0] and IV[127:0], generates a one-cycle start pulse to the core, and reports core status.
//   Sits between the AXI-Lite interconnect and the AES core control inputs. Single clock domain.
// PARAMETERS
//   ADDR_WIDTH    6   byte address width; decode uses addr[5:2], addr[1:0] ignored
//   KEY_READABLE  0   0: KEY0-3 read as 32'h0 (RRESP OKAY); 1: KEY0-3 read back stored value
// PORTS
//   clk             in   1    clock, all logic on rising edge
//   rst             in   1    asynchronous reset, active-high
//   s_axil_awaddr   in   6    write address
//   s_axil_awvalid  in   1    write address valid
//   s_axil_awready  out  1    write address ready
//   s_axil_wdata    in   32   write data
//   s_axil_wstrb    in   4    byte write strobes
//   s_axil_wvalid   in   1    write data valid
//   s_axil_wready   out  1    write data ready
//   s_axil_bresp    out  2    write response: 2'b00 OKAY, 2'b10 SLVERR
//   s_axil_bvalid   out  1    write response valid
//   s_axil_bready   in   1    write response ready
//   s_axil_araddr   in   6    read address
//   s_axil_arvalid  in   1    read address valid
//   s_axil_arready  out  1    read address ready
//   s_axil_rdata    out  32   read data
//   s_axil_rresp    out  2    read response: OKAY or SLVERR
//   s_axil_rvalid   out  1    read data valid
//   s_axil_rready   in   1    read data ready
//   key_o           out  128  AES key {KEY3,KEY2,KEY1,KEY0}
//   iv_o            out  128  initial counter {IV3,IV2,IV1,IV0}
//   key_iv_valid_o  out  1    CTRL[8] KEY_IV_VALID
//   start_o         out  1    one-cycle start pulse to core
//   core_busy_i     in   1    core is encrypting
//   core_done_i     in   1    core completion pulse
// BEHAVIOUR
//   Reset: all outputs, all registers and handshake state are 0. The *ready outputs go 1 on the first clk after rst deasserts.
//   Map: 0x00 CTRL (b0 START W/RAZ, b8 KEY_IV_VALID RW); 0x04 STATUS (b0 busy RO live, b1 DONE W1C, b2 START_ERR W1C);
//     0x10-0x1C KEY0-3; 0x20-0x2C IV0-3. Any other offset: write has no effect with BRESP SLVERR; read returns 0 with RRESP SLVERR.
//   Write channel: AW and W are accepted independently, in either order or in the same cycle. Each is latched.
//     The matching ready is 0 while its beat is held or while bvalid=1.
//   When both beats are held, the write commits on that edge, and bvalid rises the same edge.
//     bvalid holds until bready=1. The ready outputs return to 1 the cycle after the B handshake.
//     Back-to-back writes with bready tied high therefore take 3 cycles each.
//   Write strobes apply per byte to every RW field. wstrb=0 commits nothing, with BRESP OKAY.
//   KEY/IV write while core_busy_i=1: ignored, BRESP SLVERR. Otherwise the write updates the stored word and clears KEY_IV_VALID,
//     unless it is the CTRL write that sets it.
//   CTRL write with START=1 (wstrb[0]=1): this uses the post-write KEY_IV_VALID value.
//     If that value is 1 and core_busy_i=0, start_o=1 for exactly the cycle after commit.
//     Otherwise there is no pulse, START_ERR is set, and BRESP is still OKAY.
//   DONE is set by core_done_i. START_ERR is set by a rejected start. Both are cleared by writing 1.
//     If set and clear occur in the same cycle, set wins.
//   Read channel: arready=1 while rvalid=0. On AR handshake, rdata/rresp are registered and rvalid rises the next edge.
//     rvalid holds stable until rready=1. One outstanding read at a time.
//   Reads and writes are independent; a simultaneous read and write to the same register returns the pre-write value.
//   rst mid-transaction: the transaction is aborted immediately, with no B or R response, and all registers are cleared.
// TESTING
//   Write KEY0..3=2b7e1516_28aed2a6_abf71588_09cf4f3c, then IV, then CTRL=0x101, bready=1
//     -> key_o/iv_o match, start_o high exactly 1 cycle, BRESP OKAY.
//   W beat 2 cycles before AW; then AW/W in the same cycle -> one commit each, one bvalid each.
//     bvalid held while bready=0 for 3 cycles.
//   Write KEY0 with wstrb=4'b0010, data 0xAABBCCDD, over 0x11223344 -> KEY0=0x1122CC44.
//     The write clears KEY_IV_VALID, and a following CTRL=0x001 gives no start pulse and STATUS=0x4.
//   core_busy_i=1 then write IV2 -> SLVERR, IV unchanged. CTRL=0x101 while busy -> no start, START_ERR=1.
//   core_done_i pulse coincident with a STATUS write of 0x2 -> DONE stays 1. A later write of 0x2 -> DONE=0.
//   Read 0x30 -> rdata 0, SLVERR. Read KEY1 with KEY_READABLE=0 -> 0, OKAY.
//     Assert rst with bvalid pending -> bvalid=0 and key_o=0 immediately.

Source files
------------

// File: rtl/aes_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : aes_axil_regs
//  Purpose  : AXI-Lite register file for the AES-CTR core (key, IV, start
//             pulse and status).
//  Revision : 1.0  initial release
// ============================================================================
module aes_axil_regs #(
    parameter int ADDR_WIDTH   = 6,
    parameter bit KEY_READABLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [127:0]          key_o,
    output logic [127:0]          iv_o,
    output logic                  key_iv_valid_o,
    output logic                  start_o,
    input  logic                  core_busy_i,
    input  logic                  core_done_i
);
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [3:0] c_idx_ctrl    = 4'h0;
    localparam logic [3:0] c_idx_status  = 4'h1;

    logic        r_ready_en;
    logic        r_aw_held;
    logic [3:0]  r_aw_idx;
    logic        r_w_held;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_key [4];
    logic [31:0] r_iv  [4];
    logic        r_key_iv_valid;
    logic        r_done;
    logic        r_start_err;
    logic        r_start;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic        w_is_ctrl, w_is_status, w_is_key, w_is_iv, w_valid_addr;
    logic        w_strb_any, w_kv_write, w_kv_blocked;
    logic        w_kiv_next, w_start_req, w_start_ok, w_start_rej;
    logic        w_done_clr, w_serr_clr;
    logic [1:0]  w_bresp;
    logic [31:0] w_rdata;
    logic [1:0]  w_rresp;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_unused = ^{s_axil_awaddr, s_axil_araddr};

    // Readies stay low until the first edge after reset and while a beat is parked.
    assign s_axil_awready = r_ready_en & ~r_aw_held & ~r_bvalid;
    assign s_axil_wready  = r_ready_en & ~r_w_held  & ~r_bvalid;
    assign s_axil_arready = r_ready_en & ~r_rvalid;

    assign w_aw_hs  = s_axil_awvalid & s_axil_awready;
    assign w_w_hs   = s_axil_wvalid  & s_axil_wready;
    assign w_ar_hs  = s_axil_arvalid & s_axil_arready;
    assign w_commit = r_aw_held & r_w_held;

    always_comb begin
        w_is_ctrl    = (r_aw_idx == c_idx_ctrl);
        w_is_status  = (r_aw_idx == c_idx_status);
        w_is_key     = (r_aw_idx[3:2] == 2'b01);
        w_is_iv      = (r_aw_idx[3:2] == 2'b10);
        w_valid_addr = w_is_ctrl | w_is_status | w_is_key | w_is_iv;
        w_strb_any   = |r_w_strb;
        w_kv_blocked = (w_is_key | w_is_iv) & w_strb_any & core_busy_i;
        w_kv_write   = (w_is_key | w_is_iv) & w_strb_any & ~core_busy_i;
        w_bresp      = (!w_valid_addr || w_kv_blocked) ? c_resp_slverr : c_resp_okay;

        // The start decision looks at KEY_IV_VALID as it will be after this write.
        w_kiv_next = r_key_iv_valid;
        if (w_is_ctrl && r_w_strb[1]) w_kiv_next = r_w_data[8];
        else if (w_kv_write)          w_kiv_next = 1'b0;

        w_start_req = w_is_ctrl & r_w_strb[0] & r_w_data[0];
        w_start_ok  = w_start_req & w_kiv_next & ~core_busy_i;
        w_start_rej = w_start_req & ~w_start_ok;
        w_done_clr  = w_commit & w_is_status & r_w_strb[0] & r_w_data[1];
        w_serr_clr  = w_commit & w_is_status & r_w_strb[0] & r_w_data[2];
    end

    always_comb begin
        w_rdata = 32'd0;
        w_rresp = c_resp_okay;
        case (s_axil_araddr[5:2])
            4'h0:                      w_rdata = {23'd0, r_key_iv_valid, 8'd0};
            4'h1:                      w_rdata = {29'd0, r_start_err, r_done, core_busy_i};
            4'h4, 4'h5, 4'h6, 4'h7:    w_rdata = KEY_READABLE ? r_key[s_axil_araddr[3:2]] : 32'd0;
            4'h8, 4'h9, 4'hA, 4'hB:    w_rdata = r_iv[s_axil_araddr[3:2]];
            default:                   w_rresp = c_resp_slverr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_en     <= 1'b0;
            r_aw_held      <= 1'b0;
            r_aw_idx       <= 4'd0;
            r_w_held       <= 1'b0;
            r_w_data       <= 32'd0;
            r_w_strb       <= 4'd0;
            r_bvalid       <= 1'b0;
            r_bresp        <= c_resp_okay;
            r_rvalid       <= 1'b0;
            r_rdata        <= 32'd0;
            r_rresp        <= c_resp_okay;
            r_key_iv_valid <= 1'b0;
            r_done         <= 1'b0;
            r_start_err    <= 1'b0;
            r_start        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_key[i] <= 32'd0;
                r_iv[i]  <= 32'd0;
            end
        end else begin
            r_ready_en <= 1'b1;
            r_start    <= 1'b0;

            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axil_awaddr[5:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axil_wdata;
                r_w_strb <= s_axil_wstrb;
            end

            if (w_commit) begin
                r_aw_held      <= 1'b0;
                r_w_held       <= 1'b0;
                r_bvalid       <= 1'b1;
                r_bresp        <= w_bresp;
                r_key_iv_valid <= w_kiv_next;
                r_start        <= w_start_ok;
                if (w_kv_write && w_is_key)
                    r_key[r_aw_idx[1:0]] <= f_merge(r_key[r_aw_idx[1:0]], r_w_data, r_w_strb);
                if (w_kv_write && w_is_iv)
                    r_iv[r_aw_idx[1:0]] <= f_merge(r_iv[r_aw_idx[1:0]], r_w_data, r_w_strb);
            end else if (r_bvalid && s_axil_bready) begin
                r_bvalid <= 1'b0;
            end

            // A coincident set beats the W1C clear.
            r_done      <= core_done_i | (r_done & ~w_done_clr);
            r_start_err <= (w_commit & w_start_rej) | (r_start_err & ~w_serr_clr);

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (r_rvalid && s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign key_o          = {r_key[3], r_key[2], r_key[1], r_key[0]};
    assign iv_o           = {r_iv[3], r_iv[2], r_iv[1], r_iv[0]};
    assign key_iv_valid_o = r_key_iv_valid;
    assign start_o        = r_start;

endmodule
`default_nettype wire

// File: tb/tb_aes_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_axil_regs
//  Purpose  : Scoreboard bench for aes_axil_regs against a register-map model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_axil_regs;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   s_axil_awaddr;
    logic         s_axil_awvalid;
    logic         s_axil_awready;
    logic [31:0]  s_axil_wdata;
    logic [3:0]   s_axil_wstrb;
    logic         s_axil_wvalid;
    logic         s_axil_wready;
    logic [1:0]   s_axil_bresp;
    logic         s_axil_bvalid;
    logic         s_axil_bready;
    logic [5:0]   s_axil_araddr;
    logic         s_axil_arvalid;
    logic         s_axil_arready;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rvalid;
    logic         s_axil_rready;
    logic [127:0] key_o;
    logic [127:0] iv_o;
    logic         key_iv_valid_o;
    logic         start_o;
    logic         core_busy_i;
    logic         core_done_i;

    aes_axil_regs #(.ADDR_WIDTH(6), .KEY_READABLE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .key_o(key_o), .iv_o(iv_o), .key_iv_valid_o(key_iv_valid_o), .start_o(start_o),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic [1:0]  bq [$];
    rsp_t        rq [$];
    rsp_t        mon_r;
    logic [1:0]  mon_b;
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          obs_starts = 0;
    int          exp_starts = 0;
    logic [31:0] m_key [4];
    logic [31:0] m_iv  [4];
    logic        m_kiv, m_done, m_serr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected response", name);
    endtask

    // Register-map model: what each write does to the stored state.
    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int idx;
        idx  = int'(a[5:2]);
        resp = 2'b00;
        if (idx == 0) begin
            if (s[1]) m_kiv = d[8];
            if (s[0] && d[0]) begin
                if (m_kiv && !core_busy_i) exp_starts++;
                else m_serr = 1'b1;
            end
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 1'b0;
            if (s[0] && d[2]) m_serr = 1'b0;
        end else if (idx >= 4 && idx <= 11) begin
            if (s != 4'd0) begin
                if (core_busy_i) begin
                    resp = 2'b10;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) begin
                            if (idx < 8) m_key[idx-4][b*8 +: 8] = d[b*8 +: 8];
                            else         m_iv[idx-8][b*8 +: 8]  = d[b*8 +: 8];
                        end
                    end
                    m_kiv = 1'b0;
                end
            end
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [5:0] a, output rsp_t r);
        int idx;
        idx = int'(a[5:2]);
        r   = '0;
        if (idx == 0)                    r.data[8] = m_kiv;
        else if (idx == 1)               r.data = {29'd0, m_serr, m_done, core_busy_i};
        else if (idx >= 4 && idx <= 7)   r.data = 32'd0;
        else if (idx >= 8 && idx <= 11)  r.data = m_iv[idx-8];
        else                             r.resp = 2'b10;
    endtask

    // lead > 0: W is presented that many cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        logic [1:0] r;
        bit aw_done, w_done, aw_hs, w_hs;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        model_write(a, d, s, r);
        bq.push_back(r);
        while (!(aw_done && w_done)) begin
            if (!aw_done && t == (lead > 0 ? lead : 0)) begin
                s_axil_awaddr = a; s_axil_awvalid = 1'b1;
            end
            if (!w_done && t == (lead < 0 ? -lead : 0)) begin
                s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
            end
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            @(posedge clk); #1;
            if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_axil_wvalid  = 1'b0; w_done  = 1; end
            t++;
            if (t > 40) begin
                fail_now("aw_w_handshake");
                s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_b();
        int t;
        t = 0;
        while (bq.size() != 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (bq.size() != 0) begin
            fail_now("b_response");
            bq.delete();
        end
    endtask

    task automatic check_state();
        chk("key_o", key_o, {m_key[3], m_key[2], m_key[1], m_key[0]});
        chk("iv_o", iv_o, {m_iv[3], m_iv[2], m_iv[1], m_iv[0]});
        chk("key_iv_valid", key_iv_valid_o, m_kiv);
        chk("start_pulses", obs_starts, exp_starts);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        axi_write(a, d, s, lead);
        wait_b();
        check_state();
    endtask

    task automatic rd(input logic [5:0] a);
        rsp_t e;
        int t;
        bit hs;
        model_read(a, e);
        rq.push_back(e);
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        t = 0; hs = 0;
        while (!hs && t < 40) begin
            @(negedge clk);
            hs = s_axil_arready;
            @(posedge clk); #1;
            t++;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) fail_now("ar_handshake");
        t = 0;
        while (rq.size() != 0 && t < 40) begin
            s_axil_rready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            t++;
        end
        s_axil_rready = 1'b1;
        if (rq.size() != 0) begin
            fail_now("r_response");
            rq.delete();
        end
    endtask

    // Monitor: counts start pulses and scores every B and R handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (start_o) obs_starts++;
            if (s_axil_bvalid && s_axil_bready) begin
                if (bq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_b: got bresp %0h expected no response", s_axil_bresp);
                end else begin
                    mon_b = bq.pop_front();
                    chk("bresp", s_axil_bresp, mon_b);
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (rq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_r: got rdata %0h expected no response", s_axil_rdata);
                end else begin
                    mon_r = rq.pop_front();
                    chk("rdata", s_axil_rdata, mon_r.data);
                    chk("rresp", s_axil_rresp, mon_r.resp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [5:0]  ra;
        logic [31:0] rdv;
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_wvalid = 1'b0; s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b1; core_busy_i = 1'b0; core_done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_iv[i] = '0; end
        m_kiv = 1'b0; m_done = 1'b0; m_serr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", s_axil_awready, 1'b0);
        chk("rst_arready", s_axil_arready, 1'b0);
        chk("rst_bvalid", s_axil_bvalid, 1'b0);
        chk("rst_rvalid", s_axil_rvalid, 1'b0);
        chk("rst_key", key_o, 128'd0);
        chk("rst_start", start_o, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("awready_after_rst", s_axil_awready, 1'b1);

        // Load test-vector key and IV, then start.
        wr(6'h10, 32'h2b7e1516, 4'hF, 0);
        wr(6'h14, 32'h28aed2a6, 4'hF, 0);
        wr(6'h18, 32'habf71588, 4'hF, 0);
        wr(6'h1C, 32'h09cf4f3c, 4'hF, 0);
        wr(6'h20, 32'hf0f1f2f3, 4'hF, 0);
        wr(6'h24, 32'hf4f5f6f7, 4'hF, 0);
        wr(6'h28, 32'hf8f9fafb, 4'hF, 0);
        wr(6'h2C, 32'hfcfdfeff, 4'hF, 0);
        wr(6'h00, 32'h00000101, 4'hF, 0);
        chk("key_vector", key_o, 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516);
        chk("one_start", obs_starts, 1);

        // W two cycles ahead of AW, then AW/W together with B back-pressure.
        wr(6'h24, 32'h01234567, 4'hF, 2);
        s_axil_bready = 1'b0;
        axi_write(6'h28, 32'h89abcdef, 4'hF, 0);
        t = 0;
        while (!s_axil_bvalid && t < 10) begin @(posedge clk); #1; t++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bvalid_hold", s_axil_bvalid, 1'b1);
        end
        @(posedge clk); #1;
        s_axil_bready = 1'b1;
        wait_b();
        check_state();

        // Byte-strobe merge clears KEY_IV_VALID; a start then fails.
        wr(6'h00, 32'h00000100, 4'hF, 0);
        wr(6'h10, 32'h11223344, 4'hF, -1);
        wr(6'h10, 32'hAABBCCDD, 4'b0010, 1);
        chk("key0_strobe", key_o[31:0], 32'h1122CC44);
        chk("kiv_cleared", key_iv_valid_o, 1'b0);
        wr(6'h00, 32'h00000001, 4'hF, 0);
        rd(6'h04);

        // Busy core: KEY/IV writes rejected, start rejected.
        core_busy_i = 1'b1;
        wr(6'h28, 32'hdeadbeef, 4'hF, 0);
        wr(6'h00, 32'h00000101, 4'hF, 0);
        rd(6'h04);
        core_busy_i = 1'b0;
        wr(6'h04, 32'h00000004, 4'hF, 0);

        // DONE set while it is being cleared survives; a later clear works.
        core_done_i = 1'b1;
        wr(6'h04, 32'h00000002, 4'hF, 0);
        m_done = 1'b1;
        core_done_i = 1'b0;
        rd(6'h04);
        wr(6'h04, 32'h00000002, 4'hF, 0);
        rd(6'h04);

        rd(6'h30);
        rd(6'h14);
        rd(6'h28);

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            ra  = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rdv = $urandom;
            core_busy_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                core_done_i = 1'b1;
                @(posedge clk); #1;
                core_done_i = 1'b0;
                m_done = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) rd(ra);
            else wr(ra, rdv, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
        end
        core_busy_i = 1'b0;

        // Reset with a write response pending.
        s_axil_bready = 1'b0;
        axi_write(6'h10, 32'h55aa55aa, 4'hF, 0);
        t = 0;
        while (!s_axil_bvalid && t < 10) begin @(posedge clk); #1; t++; end
        chk("bvalid_pending", s_axil_bvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_abort_bvalid", s_axil_bvalid, 1'b0);
        chk("rst_abort_key", key_o, 128'd0);
        chk("rst_abort_awready", s_axil_awready, 1'b0);
        bq.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
